// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU owning HI/LO; define MDU_DIVZERO_EN to add the div_zero flag
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_EN
  ,
  output logic             div_zero
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic               is_div, neg_q, neg_r;
  logic               sx, sy, qbit;
  logic [WIDTH-1:0]   ax, ay, qfix, rfix;
  logic [WIDTH:0]     msum, dtry, ddif;
  logic [2*WIDTH-1:0] res;
`ifdef MDU_DIVZERO_EN
  logic               y_zero;
`endif
  assign busy = (state != IDLE);
  assign sx   = ~op[0] & x[WIDTH-1];
  assign sy   = ~op[0] & y[WIDTH-1];
  assign ax   = sx ? -x : x;
  assign ay   = sy ? -y : y;
  // multiply step: p holds {accumulator, remaining multiplier bits}
  assign msum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{p[0]}}};
  // divide step: p holds {partial remainder, dividend bits / quotient bits}
  assign dtry = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign ddif = dtry - {1'b0, m};
  assign qbit = ~ddif[WIDTH];
  assign qfix = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rfix = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  assign res  = is_div ? {rfix, qfix} : (neg_q ? -p : p);
  // control FSM, iterative datapath and HI/LO ownership
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MDU_DIVZERO_EN
      y_zero   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MDU_DIVZERO_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !cancel) begin
            state  <= CALC;
            cnt    <= '0;
            p      <= {{WIDTH{1'b0}}, op[1] ? ax : ay};
            m      <= op[1] ? ay : ax;
            is_div <= op[1];
            neg_q  <= sx ^ sy;
            neg_r  <= sx;
`ifdef MDU_DIVZERO_EN
            y_zero <= ~|y;
`endif
          end
        end
        CALC: begin
          cnt   <= cnt + CNT_W'(1);
          p     <= is_div ? {qbit ? ddif[WIDTH-1:0] : dtry[WIDTH-1:0], p[WIDTH-2:0], qbit}
                          : {msum, p[WIDTH-1:1]};
          state <= cancel ? IDLE : (cnt == CNT_W'(WIDTH-1) ? FIX : CALC);
        end
        FIX: begin
          state <= cancel ? IDLE : DONE;
          done  <= ~cancel;
`ifdef MDU_DIVZERO_EN
          div_zero <= ~cancel & is_div & y_zero;
          if (!cancel && !(is_div && y_zero)) {hi, lo} <= res;
`else
          if (!cancel) {hi, lo} <= res;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule
